seq_cascade_comparator: RTL and testbench

Multi-cycle magnitude comparator that drives a 2-bit-digit compare cascade sequentially. It accepts two WIDTH-bit operands over a valid/ready handshake and scans them MSB digit first, one 2-bit digit per clock. It carries the equal/greater/less cascade state between digits and returns one one-hot result over a second valid/ready handshake. It sits between the operand register file and the branch/flag logic of the CPU datapath, replacing wide combinational compare chains.

---
 rtl/seq_cascade_comparator_pkg.sv | 16 +
 rtl/seq_cascade_comparator_digit2.sv | 12 +
 rtl/seq_cascade_comparator.sv | 93 +++++++++
 tb/tb_seq_cascade_comparator.sv | 138 +++++++++++++
 4 files changed

// File: rtl/seq_cascade_comparator_pkg.sv
// compare_pkg: FSM and cascade encodings plus one-hot flag order shared by seq_cascade_comparator.
package compare_pkg;
    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;
    typedef enum logic [1:0] {EQ, GT, LT} cascade_t;
    localparam int FLAG_EQ = 0;
    localparam int FLAG_GT = 1;
    localparam int FLAG_LT = 2;
    function automatic logic [2:0] to_onehot(input cascade_t c);
        logic [2:0] f;
        f = '0;
        f[FLAG_EQ] = c == EQ;
        f[FLAG_GT] = c == GT;
        f[FLAG_LT] = c == LT;
        return f;
    endfunction
endpackage

// File: rtl/seq_cascade_comparator_digit2.sv
// digit2_compare: combinational 2-bit unsigned compare of one digit, no cascade inputs.
module digit2_compare (
    input  logic [1:0] a,
    input  logic [1:0] b,
    output logic       eq,
    output logic       gt,
    output logic       lt
);
    assign eq = a == b;
    assign gt = a > b;
    assign lt = a < b;
endmodule

// File: rtl/seq_cascade_comparator.sv
// seq_cascade_comparator: MSB-first 2-bit-digit sequential magnitude compare with valid/ready handshakes.
// Define EARLY_EXIT_EN to finish the scan as soon as the first differing digit is seen.
module seq_cascade_comparator
    import compare_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             equal,
    output logic             a_greater,
    output logic             a_less,
    output logic             busy
);
    localparam int DIGITS = WIDTH / 2;
    localparam int IW = DIGITS > 1 ? $clog2(DIGITS) : 1;

    if (WIDTH < 2 || WIDTH % 2 != 0) begin : g_bad_width
        $error("seq_cascade_comparator: WIDTH must be even and >= 2");
    end

    state_t          state, state_nx;
    cascade_t        cs, cs_nx;
    logic [IW-1:0]   idx;
    logic [WIDTH-1:0] a_q, b_q;
    logic [2:0]      flags;
    logic [1:0]      da, db;
    logic            d_eq, d_gt, d_lt, scan_end;

    assign da = a_q[2*idx +: 2];
    assign db = b_q[2*idx +: 2];

    digit2_compare u_digit (.a(da), .b(db), .eq(d_eq), .gt(d_gt), .lt(d_lt));

    // Once a higher digit has decided, lower digits are ignored.
    assign cs_nx = cs != EQ ? cs : d_gt ? GT : d_lt ? LT : EQ;

`ifdef EARLY_EXIT_EN
    assign scan_end = idx == '0 || cs_nx != EQ;
`else
    assign scan_end = idx == '0;
`endif

    always_comb begin
        state_nx = IDLE;
        state_nx = state == IDLE ? (in_valid ? SCAN : IDLE)
                 : state == SCAN ? (scan_end ? DONE : SCAN)
                 : state == DONE ? (out_ready ? IDLE : DONE)
                 : IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cs        <= EQ;
            idx       <= '0;
            a_q       <= '0;
            b_q       <= '0;
            flags     <= '0;
            out_valid <= 1'b0;
        end else begin
            state <= state_nx;
            if (state == IDLE && in_valid) begin
                a_q <= a;
                b_q <= b;
                idx <= IW'(DIGITS - 1);
                cs  <= EQ;
            end
            if (state == SCAN) begin
                cs  <= cs_nx;
                idx <= idx - 1'b1;
            end
            if (state == SCAN && scan_end) begin
                flags     <= to_onehot(cs_nx);
                out_valid <= 1'b1;
            end else if (state == DONE && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

    assign in_ready  = state == IDLE;
    assign busy      = state != IDLE;
    assign equal     = flags[FLAG_EQ];
    assign a_greater = flags[FLAG_GT];
    assign a_less    = flags[FLAG_LT];
endmodule

// File: tb/tb_seq_cascade_comparator.sv
// tb_seq_cascade_comparator: directed vectors with hand-computed flags and latencies for WIDTH=8.
module tb_seq_cascade_comparator;
    localparam int DIGITS = 4;
`ifdef EARLY_EXIT_EN
    localparam bit EE = 1'b1;
`else
    localparam bit EE = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       out_ready = 1'b0;
    logic [7:0] a = '0;
    logic [7:0] b = '0;
    logic       in_ready, out_valid, equal, a_greater, a_less, busy;
    int         n_cmp = 0;
    int         n_bad = 0;

    seq_cascade_comparator #(.WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
        .equal(equal), .a_greater(a_greater), .a_less(a_less), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic send(input string tag, input logic [7:0] av, input logic [7:0] bv);
        check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        a = av;
        b = bv;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a = '0;
        b = '0;
    endtask

    // Called #1 after the accept edge; cycle number = edges after accept + 1.
    task automatic wait_out(input string tag, input logic [2:0] fl, input int cyc_early);
        int n;
        n = 0;
        while (!out_valid && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        check({tag, "_cycle"}, 32'(n + 1), 32'(EE ? cyc_early : DIGITS + 1));
        check({tag, "_flags"}, 32'({equal, a_greater, a_less}), 32'(fl));
    endtask

    task automatic take(input string tag);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check({tag, "_idle"}, 32'({out_valid, in_ready, busy}), 32'b010);
    endtask

    task automatic run(input string tag, input logic [7:0] av, input logic [7:0] bv,
                       input logic [2:0] fl, input int cyc_early);
        send(tag, av, bv);
        wait_out(tag, fl, cyc_early);
        take(tag);
    endtask

    initial begin
        #1;
        check("rst", 32'({in_ready, out_valid, equal, a_greater, a_less, busy}), 32'b100000);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("rst_rel", 32'({in_ready, out_valid, busy}), 32'b100);

        run("eq_a5", 8'hA5, 8'hA5, 3'b100, 5);
        run("msb_gt", 8'h80, 8'h7F, 3'b010, 2);
        run("lsb_lt", 8'h12, 8'h13, 3'b001, 5);
        run("ff_00", 8'hFF, 8'h00, 3'b010, 2);
        run("d2_gt", 8'h34, 8'h24, 3'b010, 3);
        run("eq_00", 8'h00, 8'h00, 3'b100, 5);
        run("d1_lt", 8'h93, 8'h9C, 3'b001, 4);

        // Backpressure while new operands wait on in_valid.
        send("bp", 8'h40, 8'h3F);
        wait_out("bp", 3'b010, 2);
        a = 8'h01;
        b = 8'h02;
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check("bp_hold", 32'({out_valid, equal, a_greater, a_less, in_ready, busy}), 32'b101001);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("bp_hs", 32'({out_valid, in_ready, busy}), 32'b010);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("bp_accept", 32'({in_ready, busy}), 32'b01);
        wait_out("bp_new", 3'b001, 5);
        take("bp_new");

        // Reset two cycles into a scan aborts it.
        send("rs", 8'h55, 8'h55);
        @(posedge clk);
        #1;
        check("rs_scan", 32'({busy, out_valid}), 32'b10);
        rst_n = 1'b0;
        #1;
        check("rs_abort", 32'({out_valid, equal, a_greater, a_less, busy, in_ready}), 32'b000001);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            check("rs_quiet", 32'({out_valid, busy, in_ready}), 32'b001);
        end
        run("rs_after", 8'h00, 8'hFF, 3'b001, 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
